i2c_sram_bridge: RTL

I2C_SRAM_BRIDGE -- requirements
Module: i2c_sram_bridge

---
 rtl/i2c_sram_bridge.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_sram_bridge.sv
// i2c_sram_bridge: I2C slave fronting a small word-wide SRAM.
//   A write transaction loads the word pointer from its first data byte, then
//   packs the following bytes MSB-first into DATA_BYTES-wide words.
//   A read transaction streams mem[ptr] out MSB-first, most significant byte
//   first.
// Ports:
//   clk, reset     system clock, async active-high reset
//   scl, sda_in    raw I2C bus lines (asynchronous to clk)
//   sda_oe         open-drain pull-down for SDA (1 = drive low)
//   my_addr        7-bit device address
//   rcvd_mode      R/W bit of the last matching address byte (1 = read)
//   busy           addressed transaction in progress
//   wr_strobe      one-clk pulse per committed word write
//   ptr            current SRAM word pointer
// Build option: I2C_SRAM_AUTOINC_EN advances ptr after each complete word;
// without it ptr only changes through the pointer byte.
module i2c_sram_bridge #(
  parameter int DATA_BYTES = 2,
  parameter int MEM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [6:0]            my_addr,
  output logic                  rcvd_mode,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [MEM_ADDR_W-1:0] ptr
);
  localparam int         WORD_W = 8 * DATA_BYTES;
  localparam int         DEPTH  = 2 ** MEM_ADDR_W;
  localparam logic [1:0] LAST   = 2'(DATA_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ADDR_ACK, PTR, PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Bus synchronisers; reset to the idle-bus level so release never fakes an edge.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SCL must be high on both samples so an SCL edge never reads as START/STOP.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [1:0]            bidx, bidx_n;
  logic [7:0]            sh, sh_n;
  logic [WORD_W-1:0]     wr_word, wr_word_n, rd_word, rd_word_n, word_shift;
  logic [MEM_ADDR_W-1:0] ptr_n, ptr_inc;
  logic                  sda_oe_n, busy_n, mode_n, mack, mack_n;
  logic                  fetch, fetch_n, wr_strobe_n, mem_we;

  logic [WORD_W-1:0] mem [DEPTH];

  assign word_shift = (wr_word << 8) | WORD_W'(sh);

`ifdef I2C_SRAM_AUTOINC_EN
  assign ptr_inc = ptr + MEM_ADDR_W'(1);
`else
  assign ptr_inc = ptr;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= word_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      sh        <= '0;
      wr_word   <= '0;
      rd_word   <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rcvd_mode <= 1'b0;
      mack      <= 1'b0;
      fetch     <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      sh        <= sh_n;
      wr_word   <= wr_word_n;
      rd_word   <= rd_word_n;
      ptr       <= ptr_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      rcvd_mode <= mode_n;
      mack      <= mack_n;
      fetch     <= fetch_n;
      wr_strobe <= wr_strobe_n;
    end
  end

  // Bits are sampled on SCL rise; sda_oe only moves on SCL fall, so whatever
  // is driven stays stable through the following high phase.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bidx_n      = bidx;
    sh_n        = sh;
    wr_word_n   = wr_word;
    rd_word_n   = rd_word;
    ptr_n       = ptr;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    mode_n      = rcvd_mode;
    mack_n      = mack;
    fetch_n     = 1'b0;
    wr_strobe_n = 1'b0;
    mem_we      = 1'b0;
    // One fetch per word, a clk after ptr settles, well ahead of the first bit.
    if (fetch) rd_word_n = mem[ptr];
    if (start_det) begin
      state_n   = DEV_ADDR;
      cnt_n     = '0;
      bidx_n    = '0;
      sh_n      = '0;
      wr_word_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      cnt_n    = '0;
      bidx_n   = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (scl_rise) begin
      case (state)
        DEV_ADDR, PTR, WR_DATA: begin
          sh_n  = {sh[6:0], sda_s};
          cnt_n = cnt + 4'd1;
        end
        RD_DATA: cnt_n = cnt + 4'd1;
        RD_ACK: begin
          mack_n = sda_s;
          // Word finished on the master's ack bit, whether ACK or NACK.
          if (bidx == LAST) begin
            ptr_n   = ptr_inc;
            fetch_n = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        DEV_ADDR: if (cnt == 4'd8) begin
          cnt_n = '0;
          if (sh[7:1] == my_addr) begin
            state_n  = ADDR_ACK;
            sda_oe_n = 1'b1;
            busy_n   = 1'b1;
            mode_n   = sh[0];
            fetch_n  = sh[0];
          end else begin
            state_n = IGNORE;
          end
        end
        ADDR_ACK: begin
          bidx_n = '0;
          cnt_n  = '0;
          if (rcvd_mode) begin
            state_n  = RD_DATA;
            sda_oe_n = ~rd_word[WORD_W-1];
          end else begin
            state_n  = PTR;
            sda_oe_n = 1'b0;
          end
        end
        PTR: if (cnt == 4'd8) begin
          cnt_n    = '0;
          ptr_n    = sh[MEM_ADDR_W-1:0];
          state_n  = PTR_ACK;
          sda_oe_n = 1'b1;
        end
        PTR_ACK: begin
          state_n  = WR_DATA;
          sda_oe_n = 1'b0;
          bidx_n   = '0;
        end
        WR_DATA: if (cnt == 4'd8) begin
          cnt_n     = '0;
          wr_word_n = word_shift;
          state_n   = WR_ACK;
          sda_oe_n  = 1'b1;
          if (bidx == LAST) begin
            mem_we      = 1'b1;
            wr_strobe_n = 1'b1;
            ptr_n       = ptr_inc;
            bidx_n      = '0;
          end else begin
            bidx_n = bidx + 2'd1;
          end
        end
        WR_ACK: begin
          state_n  = WR_DATA;
          sda_oe_n = 1'b0;
        end
        RD_DATA: begin
          // Shift on every fall so the next byte's MSB ends up on top.
          rd_word_n = rd_word << 1;
          if (cnt == 4'd8) begin
            cnt_n    = '0;
            state_n  = RD_ACK;
            sda_oe_n = 1'b0;
          end else begin
            sda_oe_n = ~rd_word[WORD_W-2];
          end
        end
        RD_ACK: begin
          if (mack) begin
            state_n  = IGNORE;
            sda_oe_n = 1'b0;
          end else begin
            state_n  = RD_DATA;
            sda_oe_n = ~rd_word[WORD_W-1];
            bidx_n   = (bidx == LAST) ? 2'd0 : bidx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
